// File: rtl/data_cache_wb_ctrl.sv
// Write-back engine: drains one data cache line to DDR as a single write burst.
// Optional watchdog on REQ/WAIT_FIN stalls: define DATA_CACHE_WB_TIMEOUT_EN.
module data_cache_wb_ctrl #(
   parameter int DATA_CACHE_DEPTH = 16,
   parameter int CACHE_ADDR_WIDTH = 4,
   parameter int DATA_WIDTH       = 16,
   parameter int DDR_ADDR_WIDTH   = 28,
   parameter int ADDR_WIDTH_MEM   = 16,
   parameter int TIMEOUT_CYCLES   = 1023
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        store_ddr_en,
   input  logic [ADDR_WIDTH_MEM-1:0]   tag_data,
   output logic [CACHE_ADDR_WIDTH-1:0] cache_rd_addr,
   input  logic [DATA_WIDTH-1:0]       cache_rd_data,
   output logic                        wr_burst_req,
   output logic [9:0]                  wr_burst_len,
   output logic [DDR_ADDR_WIDTH-1:0]   wr_burst_addr,
   input  logic                        wr_burst_data_req,
   output logic [DATA_WIDTH-1:0]       wr_burst_data,
   input  logic                        wr_burst_finish,
   output logic [9:0]                  data_store_cnt,
   output logic                        store_busy,
   output logic                        store_done,
   output logic                        store_err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_DATA,
      S_WAIT_FIN,
      S_DONE
   } state_e;

   localparam logic [9:0] DEPTH_C = 10'(DATA_CACHE_DEPTH);

   state_e                    state_q;
   logic                      en_dly_q;
   logic [ADDR_WIDTH_MEM-1:0] tag_q;
   logic                      req_q;
   logic [DATA_WIDTH-1:0]     data_q;
   logic [9:0]                cnt_q;
   logic                      done_q;
   logic                      err_q;

   logic                      start;
   logic                      svc_ok;
   logic [9:0]                cnt_d;
   logic                      fin_short;
   logic                      wd_expired;

`ifdef DATA_CACHE_WB_TIMEOUT_EN
   localparam logic [9:0] WD_LAST = 10'(TIMEOUT_CYCLES - 1);
   logic [9:0] wd_q;
   assign wd_expired = (wd_q == WD_LAST);
`else
   assign wd_expired = 1'b0;
`endif

   assign start     = store_ddr_en && !en_dly_q;
   assign svc_ok    = (cnt_q < DEPTH_C);
   // Count as it will be after servicing this cycle's request; decides short vs. full burst on finish.
   assign cnt_d     = (wr_burst_data_req && svc_ok) ? cnt_q + 10'd1 : cnt_q;
   assign fin_short = (cnt_d < DEPTH_C);

   assign cache_rd_addr  = cnt_q[CACHE_ADDR_WIDTH-1:0];
   assign wr_burst_len   = DEPTH_C;
   assign wr_burst_addr  = DDR_ADDR_WIDTH'({tag_q, 3'b000});
   assign wr_burst_req   = req_q;
   assign wr_burst_data  = data_q;
   assign data_store_cnt = cnt_q;
   assign store_busy     = (state_q != S_IDLE);
   assign store_done     = done_q;
   assign store_err      = err_q;

   // NOTE: all state is updated with non-blocking assignments so every branch reads pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         en_dly_q <= 1'b0;
         tag_q    <= '0;
         req_q    <= 1'b0;
         data_q   <= '0;
         cnt_q    <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
`ifdef DATA_CACHE_WB_TIMEOUT_EN
         wd_q     <= '0;
`endif
      end else begin
         en_dly_q <= store_ddr_en;
         done_q   <= 1'b0;
`ifdef DATA_CACHE_WB_TIMEOUT_EN
         wd_q     <= '0;
`endif
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  tag_q   <= tag_data;
                  cnt_q   <= '0;
                  err_q   <= 1'b0;
                  req_q   <= 1'b1;
                  state_q <= S_REQ;
               end
            end
            S_REQ, S_DATA: begin
               if (wr_burst_data_req) begin
                  if (svc_ok) begin
                     data_q <= cache_rd_data;
                     cnt_q  <= cnt_q + 10'd1;
                  end else begin
                     data_q <= '0;
                     err_q  <= 1'b1;
                  end
               end
               if (wr_burst_finish) begin
                  req_q   <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
                  if (fin_short) err_q <= 1'b1;
               end else if (state_q == S_REQ) begin
                  if (wr_burst_data_req) begin
                     req_q   <= 1'b0;
                     state_q <= S_DATA;
                  end else if (wd_expired) begin
                     req_q   <= 1'b0;
                     err_q   <= 1'b1;
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
`ifdef DATA_CACHE_WB_TIMEOUT_EN
                     wd_q <= wd_q + 10'd1;
`endif
                  end
               end else if (cnt_q == DEPTH_C) begin
                  state_q <= S_WAIT_FIN;
               end
            end
            S_WAIT_FIN: begin
               if (wr_burst_finish) begin
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else if (wd_expired) begin
                  err_q   <= 1'b1;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else begin
`ifdef DATA_CACHE_WB_TIMEOUT_EN
                  wd_q <= wd_q + 10'd1;
`endif
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_cache_wb_ctrl.sv
// Directed bench for data_cache_wb_ctrl; the bench plays the DDR write port and a cache holding 0xA000+i.
module tb_data_cache_wb_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        store_ddr_en;
   logic [15:0] tag_data;
   logic [3:0]  cache_rd_addr;
   logic [15:0] cache_rd_data;
   logic        wr_burst_req;
   logic [9:0]  wr_burst_len;
   logic [27:0] wr_burst_addr;
   logic        wr_burst_data_req;
   logic [15:0] wr_burst_data;
   logic        wr_burst_finish;
   logic [9:0]  data_store_cnt;
   logic        store_busy;
   logic        store_done;
   logic        store_err;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   assign cache_rd_data = 16'hA000 + {12'h000, cache_rd_addr};

   data_cache_wb_ctrl dut (
      .clk               (clk),
      .rst               (rst),
      .store_ddr_en      (store_ddr_en),
      .tag_data          (tag_data),
      .cache_rd_addr     (cache_rd_addr),
      .cache_rd_data     (cache_rd_data),
      .wr_burst_req      (wr_burst_req),
      .wr_burst_len      (wr_burst_len),
      .wr_burst_addr     (wr_burst_addr),
      .wr_burst_data_req (wr_burst_data_req),
      .wr_burst_data     (wr_burst_data),
      .wr_burst_finish   (wr_burst_finish),
      .data_store_cnt    (data_store_cnt),
      .store_busy        (store_busy),
      .store_done        (store_done),
      .store_err         (store_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Rising edge on store_ddr_en; returns at the first negedge in REQ.
   task automatic start_burst(input logic [15:0] t);
      tag_data     = t;
      store_ddr_en = 1'b1;
      tick();
   endtask

   task automatic send_words(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         wr_burst_data_req = 1'b1;
         tick();
         check({tag, "_data"}, 32'(wr_burst_data), 32'(16'hA000 + i));
         check({tag, "_cnt"}, 32'(data_store_cnt), 32'(i + 1));
      end
      wr_burst_data_req = 1'b0;
   endtask

   task automatic finish_pulse();
      wr_burst_finish = 1'b1;
      tick();
      wr_burst_finish = 1'b0;
   endtask

   initial begin
      rst               = 1'b0;
      store_ddr_en      = 1'b0;
      tag_data          = 16'h0000;
      wr_burst_data_req = 1'b0;
      wr_burst_finish   = 1'b0;
      #3;
      check("rst_req",  32'(wr_burst_req),   32'd0);
      check("rst_busy", 32'(store_busy),     32'd0);
      check("rst_len",  32'(wr_burst_len),   32'd16);
      tick();
      tick();
      rst = 1'b1;
      tick();
      check("idle_cnt",  32'(data_store_cnt), 32'd0);
      check("idle_addr", 32'(wr_burst_addr),  32'd0);
      check("idle_done", 32'(store_done),     32'd0);

      // Normal write-back, then level hold
      start_burst(16'h0040);
      check("n_req",  32'(wr_burst_req),  32'd1);
      check("n_busy", 32'(store_busy),    32'd1);
      check("n_addr", 32'(wr_burst_addr), 32'h0000200);
      check("n_len",  32'(wr_burst_len),  32'd16);
      check("n_cnt0", 32'(data_store_cnt), 32'd0);
      wr_burst_data_req = 1'b1;
      tick();
      check("n_req_drop", 32'(wr_burst_req), 32'd0);
      check("n_data0",    32'(wr_burst_data), 32'hA000);
      wr_burst_data_req = 1'b0;
      tick();
      wr_burst_data_req = 1'b1;
      for (int i = 1; i < 16; i++) begin
         tick();
         check("n_data", 32'(wr_burst_data), 32'(16'hA000 + i));
      end
      wr_burst_data_req = 1'b0;
      tick();
      check("n_wait_busy", 32'(store_busy), 32'd1);
      check("n_wait_done", 32'(store_done), 32'd0);
      finish_pulse();
      check("n_done", 32'(store_done),     32'd1);
      check("n_err",  32'(store_err),      32'd0);
      check("n_cnt",  32'(data_store_cnt), 32'd16);
      tick();
      check("n_done_pulse", 32'(store_done), 32'd0);
      check("n_idle",       32'(store_busy), 32'd0);
      repeat (5) tick();
      check("hold_no_retrig_busy", 32'(store_busy),   32'd0);
      check("hold_no_retrig_req",  32'(wr_burst_req), 32'd0);

      // Toggle request and change tag mid-DATA
      store_ddr_en = 1'b0;
      tick();
      start_burst(16'h0100);
      check("b_addr", 32'(wr_burst_addr), 32'h0000800);
      for (int i = 0; i < 16; i++) begin
         if (i == 5) store_ddr_en = 1'b0;
         if (i == 8) begin
            store_ddr_en = 1'b1;
            tag_data     = 16'h1234;
         end
         wr_burst_data_req = 1'b1;
         tick();
         check("b_data", 32'(wr_burst_data), 32'(16'hA000 + i));
      end
      wr_burst_data_req = 1'b0;
      check("b_addr_mid", 32'(wr_burst_addr), 32'h0000800);
      tick();
      finish_pulse();
      check("b_done", 32'(store_done), 32'd1);
      repeat (5) tick();
      check("b_no_extra", 32'(store_busy),    32'd0);
      check("b_addr_end", 32'(wr_burst_addr), 32'h0000800);
      store_ddr_en = 1'b0;
      tick();

      // Short burst: finish after 10 words
      start_burst(16'h0003);
      check("s_addr", 32'(wr_burst_addr), 32'h0000018);
      send_words(10, "s");
      tick();
      check("s_err_pre", 32'(store_err), 32'd0);
      finish_pulse();
      check("s_done", 32'(store_done),     32'd1);
      check("s_err",  32'(store_err),      32'd1);
      check("s_cnt",  32'(data_store_cnt), 32'd10);
      tick();
      check("s_err_hold", 32'(store_err),      32'd1);
      check("s_cnt_hold", 32'(data_store_cnt), 32'd10);
      store_ddr_en = 1'b0;
      tick();

      // Overrun: 17 back-to-back requests
      start_burst(16'h0007);
      check("o_err_clr", 32'(store_err),      32'd0);
      check("o_cnt_clr", 32'(data_store_cnt), 32'd0);
      send_words(16, "o");
      wr_burst_data_req = 1'b1;
      tick();
      wr_burst_data_req = 1'b0;
      check("o_data", 32'(wr_burst_data),  32'd0);
      check("o_cnt",  32'(data_store_cnt), 32'd16);
      check("o_err",  32'(store_err),      32'd1);
      tick();
      finish_pulse();
      check("o_done", 32'(store_done), 32'd1);
      check("o_err2", 32'(store_err),  32'd1);
      tick();
      store_ddr_en = 1'b0;
      tick();

      // Finish coincident with the last request
      start_burst(16'h0002);
      send_words(15, "c");
      wr_burst_data_req = 1'b1;
      wr_burst_finish   = 1'b1;
      tick();
      wr_burst_data_req = 1'b0;
      wr_burst_finish   = 1'b0;
      check("c_done", 32'(store_done),     32'd1);
      check("c_err",  32'(store_err),      32'd0);
      check("c_cnt",  32'(data_store_cnt), 32'd16);
      check("c_data", 32'(wr_burst_data),  32'hA00F);
      tick();
      store_ddr_en = 1'b0;
      tick();

      // Asynchronous reset in DATA
      start_burst(16'h0009);
      send_words(5, "r");
      #2;
      rst          = 1'b0;
      store_ddr_en = 1'b0;
      #1;
      check("r_req",  32'(wr_burst_req),   32'd0);
      check("r_data", 32'(wr_burst_data),  32'd0);
      check("r_cnt",  32'(data_store_cnt), 32'd0);
      check("r_busy", 32'(store_busy),     32'd0);
      check("r_done", 32'(store_done),     32'd0);
      check("r_addr", 32'(wr_burst_addr),  32'd0);
      tick();
      rst = 1'b1;
      tick();
      check("r_stay_idle", 32'(store_busy), 32'd0);

      // No data request after start
      start_burst(16'h0001);
`ifdef DATA_CACHE_WB_TIMEOUT_EN
      begin
         int n = 0;
         while (!store_done && n < 1100) begin
            tick();
            n++;
         end
         check("t_cycles", 32'(n), 32'd1023);
         check("t_err",    32'(store_err),    32'd1);
         check("t_req",    32'(wr_burst_req), 32'd0);
      end
`else
      repeat (1100) tick();
      check("t_req_held",  32'(wr_burst_req), 32'd1);
      check("t_busy_held", 32'(store_busy),   32'd1);
      check("t_no_err",    32'(store_err),    32'd0);
`endif
      store_ddr_en = 1'b0;
      rst          = 1'b0;
      tick();
      rst = 1'b1;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
